serial_comparator: RTL

SERIAL_COMPARATOR -- requirements
Module: serial_comparator

---
 rtl/comp_pkg.sv | 30 +++
 rtl/serial_bit_counter.sv | 41 ++++
 rtl/serial_comparator.sv | 112 +++++++++++
 3 files changed

// File: rtl/comp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, the running
// decision, and the single-bit decision update rule.
package comp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    EQ = 2'd0,
    GT = 2'd1,
    LT = 2'd2
  } dec_e;

  // Advance the running decision by one MSB-first bit pair. Only an EQ
  // decision can change; the first differing pair settles it for good.
  // invert_gt flips the sense of the difference (used for a sign bit).
  function automatic dec_e dec_update(input dec_e cur, input logic a_bit,
                                      input logic b_bit, input logic invert_gt);
    dec_e res;
    res = cur;
    if (cur == EQ && a_bit != b_bit) begin
      res = (a_bit ^ invert_gt) ? GT : LT;
    end
    return res;
  endfunction

endpackage

// File: rtl/serial_bit_counter.sv
// Bit-position counter for the serial comparator. Clears on request, counts
// enabled bits and saturates at DATA_WIDTH-1 so it never wraps inside one
// comparison. tc_out flags the last bit position, first_out the first.
module serial_bit_counter #(
  parameter int DATA_WIDTH = 4,
  localparam int CW = $clog2(DATA_WIDTH)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_in,
  input  logic enable_in,
  output logic tc_out,
  output logic first_out
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc_out    = (count_q == CW'(DATA_WIDTH - 1));
  assign first_out = (count_q == '0);

  // Next count: clear wins, otherwise step until the terminal position.
  always_comb begin
    count_d = count_q;
    if (clear_in) begin
      count_d = '0;
    end else if (enable_in && !tc_out) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/serial_comparator.sv
// Serial MSB-first magnitude comparator. A start in IDLE opens a comparison,
// each valid bit pair refines an EQ/GT/LT decision, and after DATA_WIDTH
// valid pairs the result is latched into the flags with a one-cycle done.
// Build option: define SERIAL_COMP_SIGNED_EN to treat operands as two's
// complement (the first bit received is the sign bit).
module serial_comparator
  import comp_pkg::*;
#(
  parameter int DATA_WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start_in,
  input  logic bit_valid_in,
  input  logic a_bit_in,
  input  logic b_bit_in,
  output logic busy_out,
  output logic done_out,
  output logic a_g_b_out,
  output logic a_e_b_out,
  output logic a_l_b_out
);

  state_e state_q, state_d;
  dec_e   dec_q, dec_d;
  logic   gt_q, eq_q, lt_q;
  logic   cnt_clear, cnt_en, cnt_tc, cnt_first;
  logic   load_flags;
  logic   invert_gt;

  serial_bit_counter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_bit_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_in  (cnt_clear),
    .enable_in (cnt_en),
    .tc_out    (cnt_tc),
    .first_out (cnt_first)
  );

`ifdef SERIAL_COMP_SIGNED_EN
  // The sign bit arrives first: a set sign on A alone means A is smaller.
  assign invert_gt = cnt_first;
`else
  // Unsigned operands: every bit compares the same way, so the
  // first-position indicator is intentionally left unused.
  logic unused_cnt_first;
  assign unused_cnt_first = cnt_first;
  assign invert_gt        = 1'b0;
`endif

  assign busy_out  = (state_q == SHIFT) || (state_q == DONE);
  assign done_out  = (state_q == DONE);
  assign a_g_b_out = gt_q;
  assign a_e_b_out = eq_q;
  assign a_l_b_out = lt_q;

  // Next-state, decision update and counter control.
  always_comb begin
    state_d    = state_q;
    dec_d      = dec_q;
    cnt_clear  = 1'b0;
    cnt_en     = 1'b0;
    load_flags = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d   = SHIFT;
          cnt_clear = 1'b1;
          dec_d     = EQ;
        end
      end
      SHIFT: begin
        if (bit_valid_in) begin
          cnt_en = 1'b1;
          dec_d  = dec_update(dec_q, a_bit_in, b_bit_in, invert_gt);
          if (cnt_tc) begin
            state_d    = DONE;
            load_flags = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, running decision and result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      dec_q   <= EQ;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dec_q   <= dec_d;
      if (load_flags) begin
        gt_q <= (dec_d == GT);
        eq_q <= (dec_d == EQ);
        lt_q <= (dec_d == LT);
      end
    end
  end

endmodule
